// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - Counter-based clock divider with a registered, glitch-free 50% duty output
module clk_divider #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int OUT_FREQ_HZ = 100
) (
    input  logic clk_50mhz,
    input  logic rst,
    output logic clk_100hz
);

    // Input cycles per output half-period; a zero output frequency yields 0 so the check below fires
    localparam int HALF_COUNT = (OUT_FREQ_HZ == 0) ? 0 : CLK_FREQ_HZ / (2 * OUT_FREQ_HZ);
    localparam int CNT_W      = (HALF_COUNT > 1) ? $clog2(HALF_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_COUNT - 1);

    // Refuse to build a divider that cannot produce a toggle
    generate
        if (OUT_FREQ_HZ == 0 || HALF_COUNT < 1) begin : g_bad_params
            $error("clk_divider: OUT_FREQ_HZ must be nonzero and HALF_COUNT at least 1");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic             r_clk;
    logic             w_terminal;

    assign w_terminal = (r_cnt == LAST);

    // Count input cycles within a half-period and flip the output at the terminal count; reset wins
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
        end else if (w_terminal) begin
            r_cnt <= '0;
            r_clk <= ~r_clk;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Output comes straight from the flop so it cannot glitch
    assign clk_100hz = r_clk;

endmodule

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - Scoreboard bench for clk_divider with HALF_COUNT of 5, 1 and 8
module tb_clk_divider;

    typedef struct {
        int   e;
        logic v;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] outs;

    exp_t q [3][$];
    logic [2:0] prev;
    bit   mon_en;
    int   edge_no;
    int   n_checks;
    int   n_fail;

    // Divide ratios: 1000/(2*100)=5, 200/(2*100)=1, 1600/(2*100)=8
    clk_divider #(.CLK_FREQ_HZ(1000), .OUT_FREQ_HZ(100)) u_h5 (
        .clk_50mhz(clk), .rst(rst), .clk_100hz(outs[0]));
    clk_divider #(.CLK_FREQ_HZ(200),  .OUT_FREQ_HZ(100)) u_h1 (
        .clk_50mhz(clk), .rst(rst), .clk_100hz(outs[1]));
    clk_divider #(.CLK_FREQ_HZ(1600), .OUT_FREQ_HZ(100)) u_h8 (
        .clk_50mhz(clk), .rst(rst), .clk_100hz(outs[2]));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic int half_of(input int i);
        case (i)
            0:       return 5;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    task automatic check(input bit ok, input string name, input int inst, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s inst=%0d edge=%0d actual=%0d required=%0d", name, inst, edge_no, act, req);
        end
    endtask

    // Expected toggles for release after edge e_rel, reset asserted after edge a_end
    task automatic push_segment(input int e_rel, input int a_end);
        for (int i = 0; i < 3; i++) begin
            int   h;
            exp_t x;
            h = half_of(i);
            for (int k = 1; e_rel + k * h <= a_end; k++) begin
                x.e = e_rel + k * h;
                x.v = logic'(k % 2);
                q[i].push_back(x);
            end
            if ((((a_end - e_rel) / h) % 2) == 1) begin
                x.e = a_end + 1;
                x.v = 1'b0;
                q[i].push_back(x);
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(posedge clk);
            edge_no++;
            #1;
            if (mon_en) begin
                for (int i = 0; i < 3; i++) begin
                    while (q[i].size() > 0 && q[i][0].e < edge_no) begin
                        check(1'b0, "missed_toggle", i, edge_no, q[i][0].e);
                        void'(q[i].pop_front());
                    end
                    if (outs[i] !== prev[i]) begin
                        if (q[i].size() == 0) begin
                            check(1'b0, "unexpected_toggle", i, edge_no, 0);
                        end else begin
                            exp_t x;
                            x = q[i].pop_front();
                            check(x.e == edge_no, "toggle_edge", i, edge_no, x.e);
                            check(outs[i] === x.v, "toggle_value", i, int'(outs[i]), int'(x.v));
                        end
                    end
                    prev[i] = outs[i];
                end
            end
        end
    endtask

    task automatic run_segment(input int len, input int hold);
        int e_rel;
        rst   = 1'b0;
        e_rel = edge_no;
        push_segment(e_rel, e_rel + len);
        repeat (len) @(negedge clk);
        rst = 1'b1;
        repeat (hold) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        mon_en   = 1'b0;
        prev     = 3'b000;
        edge_no  = 0;
        n_checks = 0;
        n_fail   = 0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            check(outs[i] === 1'b0, "reset_state", i, int'(outs[i]), 0);
        prev   = outs;
        mon_en = 1'b1;

        // Long run, reset lands mid high phase (and on the terminal edge of the /8 divider)
        run_segment(47, 1);
        // Reset lands on a terminal edge while low: reset must beat the 0->1 toggle
        run_segment(44, 3);
        for (int i = 0; i < 2; i++)
            check(outs[i] === 1'b0, "reset_priority_low", i, int'(outs[i]), 0);
        run_segment(30, 2);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check(q[i].size() == 0, "pending_toggles", i, q[i].size(), 0);
            check(outs[i] === 1'b0, "final_reset_state", i, int'(outs[i]), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_divider.md
CLK_DIVIDER -- requirements
Module: clk_divider

Interface
REQ-001 The block SHALL have one clock, clk_50mhz; reset rst is synchronous and active-high, sampled only on the rising edge of clk_50mhz.
REQ-002 Parameter CLK_FREQ_HZ SHALL default to 50_000_000; it is the input clock frequency in Hz.
REQ-003 Parameter OUT_FREQ_HZ SHALL default to 100; it is the output clock frequency in Hz.
REQ-004 Derived constant HALF_COUNT SHALL equal floor(CLK_FREQ_HZ / (2*OUT_FREQ_HZ)), which is 250_000 at the defaults.
REQ-005 Derived constant CNT_W SHALL equal max(1, ceil(log2(HALF_COUNT))), which is 18 at the defaults.
REQ-006 clk_50mhz  input  1  free-running reference clock (20 ns period at default).
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 clk_100hz  output  1  divided clock, 50% duty, period 2*HALF_COUNT input cycles (10 ms at default).

Function
REQ-009 The block SHALL hold an internal CNT_W-bit counter cnt and a 1-bit output register driving clk_100hz directly, with no combinational logic after the flop, so the output is glitch-free.
REQ-010 On each rising edge with rst=0 and cnt != HALF_COUNT-1, cnt SHALL increment by 1 and clk_100hz SHALL hold its value.
REQ-011 On each rising edge with rst=0 and cnt == HALF_COUNT-1, cnt SHALL load 0 and clk_100hz SHALL invert.
REQ-012 cnt SHALL never exceed HALF_COUNT-1; no other wrap path exists.
REQ-013 clk_100hz SHALL toggle exactly every HALF_COUNT input cycles, giving high and low phases of equal length (250_000 cycles each at default).
REQ-014 The first toggle after reset release SHALL occur on the HALF_COUNT-th rising edge sampled with rst=0, and that toggle SHALL be 0->1.
REQ-015 If HALF_COUNT == 1, clk_100hz SHALL toggle on every rising edge with rst=0 (divide-by-2).
REQ-016 Elaboration SHALL fail (static check) if OUT_FREQ_HZ == 0 or HALF_COUNT < 1.
REQ-017 No state other than cnt and the output register is permitted; there are no enables or further ports.

Reset
REQ-018 On any rising edge with rst=1, cnt SHALL be set to 0 and clk_100hz SHALL be set to 0.
REQ-019 Reset SHALL take priority over the terminal-count toggle when both apply on the same edge.
REQ-020 Reset asserted mid-period, in either output phase, SHALL discard the partial count; after release, timing restarts per REQ-014.
REQ-021 Before the first rising edge with rst=1, output value is not required; a bench SHALL apply reset for at least 1 cycle.

Verification
REQ-022 Default parameters, clk 20 ns (first rising edge at 10 ns), rst=1 until 100 ns -> clk_100hz=0 through 5,000,089 ns; 0->1 at the 5,000,090 ns edge; 1->0 at 10,000,090 ns; 0->1 at 15,000,090 ns; continuing every 5,000,000 ns up to 30 ms.
REQ-023 Measured over 30 ms after reset -> every high and low phase is exactly 250,000 input cycles; the full period is 500,000 cycles (10 ms); no glitches.
REQ-024 Assert rst for 1 cycle while clk_100hz=1 and cnt≈100,000 -> output is 0 on the next edge; next 0->1 occurs 250,000 edges after release.
REQ-025 Assert rst on the exact edge where cnt == 249,999 -> no toggle; output 0; cnt 0 (reset priority).
REQ-026 Override CLK_FREQ_HZ=1000, OUT_FREQ_HZ=100 (HALF_COUNT=5) -> output toggles every 5 cycles, first 0->1 on the 5th edge after release; override HALF_COUNT=1 case -> toggles every edge.
